// File: rtl/lc3_mem_ctrl_if.sv
// Signal bundle between the LC-3 datapath/control, the memory controller, the SRAM and the console devices.
interface lc3_mem_ctrl_if;
   logic [15:0] main_bus;
   logic        ld_mar;
   logic        ld_mdr;
   logic        mio_en;
   logic        r_w;
   logic [15:0] mdr_out;
   logic [15:0] mar_out;
   logic        R;
   logic        INT;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        kb_valid;
   logic [7:0]  kb_data;
   logic        kb_ready;
   logic        ddr_valid;
   logic [7:0]  ddr_data;
   logic        ddr_ack;

   modport master (
      output main_bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, kb_valid, kb_data, ddr_ack,
      input  mdr_out, mar_out, R, INT, mem_en, mem_we, mem_addr, mem_wdata, kb_ready,
             ddr_valid, ddr_data
   );

   modport slave (
      input  main_bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, kb_valid, kb_data, ddr_ack,
      output mdr_out, mar_out, R, INT, mem_en, mem_we, mem_addr, mem_wdata, kb_ready,
             ddr_valid, ddr_data
   );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO stage: owns MAR/MDR, sequences wait-stated SRAM accesses and
// implements the memory-mapped keyboard and display registers.
module lc3_mem_ctrl #(
   parameter int unsigned WAIT_STATES = 2
) (
   input logic           clk,
   input logic           rst,
   lc3_mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

   state_t      state, state_next;
   logic [3:0]  count, count_next;
   logic        first, first_next;
   logic        wr, wr_next;
   logic [15:0] mar, mdr, ddr;
   logic [7:0]  kbdr;
   logic        kb_full, kb_ie, ddr_pend;
   logic        io_sel, done_rd, done_wr, kbdr_rd;
   logic [15:0] io_rdata;

   assign io_sel  = (mar[15:8] == 8'hFE);
   assign done_rd = (state == DONE) && !wr;
   assign done_wr = (state == DONE) && wr;
   assign kbdr_rd = done_rd && (mar == KBDR_ADDR);

   always_comb begin
      io_rdata = 16'h0000;
      case (mar)
         KBSR_ADDR: io_rdata = {kb_full, kb_ie, 14'h0000};
         KBDR_ADDR: io_rdata = {8'h00, kbdr};
         DSR_ADDR:  io_rdata = {~ddr_pend, 15'h0000};
         DDR_ADDR:  io_rdata = ddr;
         default:   io_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         count <= 4'd0;
         first <= 1'b0;
         wr    <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         first <= first_next;
         wr    <= wr_next;
      end
   end

   // r_w is latched on entry so the strobes depend only on registered state
   always_comb begin
      state_next = state;
      count_next = count;
      first_next = 1'b0;
      wr_next    = wr;
      case (state)
         IDLE: begin
            if (bus.mio_en) begin
               wr_next = bus.r_w;
               if (io_sel) begin
                  state_next = DONE;
               end else begin
                  state_next = ACCESS;
                  count_next = WAIT_INIT;
                  first_next = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (count == 4'd0) state_next = DONE;
            else               count_next = count - 4'd1;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mar      <= 16'h0000;
         mdr      <= 16'h0000;
         kbdr     <= 8'h00;
         kb_full  <= 1'b0;
         kb_ie    <= 1'b0;
         ddr      <= 16'h0000;
         ddr_pend <= 1'b0;
      end else begin
         if (bus.ld_mar) mar <= bus.main_bus;

         if (bus.ld_mdr && !bus.mio_en)  mdr <= bus.main_bus;
         else if (bus.ld_mdr && done_rd) mdr <= io_sel ? io_rdata : bus.mem_rdata;

         // A KBDR read wins over a same-cycle capture; kb_ready was low so nothing is lost
         if (kbdr_rd) begin
            kb_full <= 1'b0;
         end else if (bus.kb_valid && !kb_full) begin
            kbdr    <= bus.kb_data;
            kb_full <= 1'b1;
         end

         if (done_wr && mar == KBSR_ADDR) kb_ie <= mdr[14];

         if (done_wr && mar == DDR_ADDR) begin
            ddr      <= mdr;
            ddr_pend <= 1'b1;
         end else if (bus.ddr_ack && ddr_pend) begin
            ddr_pend <= 1'b0;
         end
      end
   end

   assign bus.mdr_out   = mdr;
   assign bus.mar_out   = mar;
   assign bus.R         = (state == DONE);
   assign bus.mem_en    = (state == ACCESS) && first;
   assign bus.mem_we    = (state == ACCESS) && first && wr;
   assign bus.mem_addr  = mar;
   assign bus.mem_wdata = mdr;
   assign bus.INT       = kb_full & kb_ie;
   assign bus.kb_ready  = ~kb_full;
   assign bus.ddr_valid = ddr_pend;
   assign bus.ddr_data  = ddr[7:0];

   mar_rw_stable: assert property (@(posedge clk) disable iff (!rst)
      (state != IDLE) |-> ($stable(mar) && $stable(bus.r_w)));
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: SRAM responder, timestamp-based reference model
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_lc3_mem_ctrl;
   localparam int WS = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   lc3_mem_ctrl_if bus();

   lc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   logic [15:0] sram [0:65535];
   logic [15:0] rdata_q = 16'h0000;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
            rdata_q            <= 16'hDEAD;
         end else begin
            rdata_q <= sram[bus.mem_addr];
         end
      end
   end
   assign bus.mem_rdata = rdata_q;

   // Reference model: each access is scheduled by absolute cycle numbers
   int          cyc = 0;
   int          r_at, en_at;
   bit          busy, acc_io, acc_wr, model_on = 1'b0;
   logic [15:0] m_mar, m_mdr, m_ddr;
   logic [7:0]  m_kbdr;
   bit          m_kb_full, m_kb_ie, m_ddr_pend;
   logic [15:0] m_mem [0:65535];
   logic        exp_r, exp_en, exp_we, kb_clear, start_io;

   assign exp_r    = busy && (cyc == r_at);
   assign exp_en   = busy && !acc_io && (cyc == en_at);
   assign exp_we   = exp_en && acc_wr;
   assign kb_clear = exp_r && !acc_wr && acc_io && (m_mar == 16'hFE02);
   assign start_io = (m_mar[15:8] == 8'hFE);

   function automatic logic [15:0] dev_read(input logic [15:0] a);
      case (a)
         16'hFE00: return {m_kb_full, m_kb_ie, 14'h0000};
         16'hFE02: return {8'h00, m_kbdr};
         16'hFE04: return {!m_ddr_pend, 15'h0000};
         16'hFE06: return m_ddr;
         default:  return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         model_on   <= 1'b1;
         busy       <= 1'b0;
         m_mar      <= 16'h0000;
         m_mdr      <= 16'h0000;
         m_kbdr     <= 8'h00;
         m_kb_full  <= 1'b0;
         m_kb_ie    <= 1'b0;
         m_ddr      <= 16'h0000;
         m_ddr_pend <= 1'b0;
      end else begin
         if (bus.ld_mar) m_mar <= bus.main_bus;
         if (bus.ld_mdr && !bus.mio_en) m_mdr <= bus.main_bus;
         if (!busy && bus.mio_en) begin
            busy   <= 1'b1;
            acc_io <= start_io;
            acc_wr <= bus.r_w;
            en_at  <= cyc + 1;
            r_at   <= cyc + (start_io ? 1 : 2 + WS);
            if (!start_io && bus.r_w) m_mem[m_mar] <= m_mdr;
         end
         if (bus.ddr_ack && m_ddr_pend) m_ddr_pend <= 1'b0;
         if (exp_r) begin
            busy <= 1'b0;
            if (!acc_wr && bus.ld_mdr) m_mdr <= acc_io ? dev_read(m_mar) : m_mem[m_mar];
            if (acc_wr && acc_io && m_mar == 16'hFE00) m_kb_ie <= m_mdr[14];
            if (acc_wr && acc_io && m_mar == 16'hFE06) begin
               m_ddr      <= m_mdr;
               m_ddr_pend <= 1'b1;
            end
         end
         if (kb_clear) m_kb_full <= 1'b0;
         else if (bus.kb_valid && !m_kb_full) begin
            m_kbdr    <= bus.kb_data;
            m_kb_full <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("cmp_R", {15'h0, bus.R}, {15'h0, exp_r});
         check("cmp_mem_en", {15'h0, bus.mem_en}, {15'h0, exp_en});
         check("cmp_mem_we", {15'h0, bus.mem_we}, {15'h0, exp_we});
         check("cmp_mar", bus.mar_out, m_mar);
         check("cmp_mdr", bus.mdr_out, m_mdr);
         check("cmp_mem_addr", bus.mem_addr, m_mar);
         check("cmp_mem_wdata", bus.mem_wdata, m_mdr);
         check("cmp_INT", {15'h0, bus.INT}, {15'h0, m_kb_full & m_kb_ie});
         check("cmp_kb_ready", {15'h0, bus.kb_ready}, {15'h0, !m_kb_full});
         check("cmp_ddr_valid", {15'h0, bus.ddr_valid}, {15'h0, m_ddr_pend});
         check("cmp_ddr_data", {8'h00, bus.ddr_data}, {8'h00, m_ddr[7:0]});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_regs(input logic [15:0] mar_v, input logic [15:0] mdr_v, input bit set_mdr);
      bus.main_bus = mar_v;
      bus.ld_mar   = 1'b1;
      tick();
      bus.ld_mar = 1'b0;
      if (set_mdr) begin
         bus.main_bus = mdr_v;
         bus.ld_mdr   = 1'b1;
         tick();
         bus.ld_mdr = 1'b0;
      end
   endtask

   // Holds mio_en until R, then drops it in the following IDLE cycle
   task automatic do_access(input logic wr, output int lat);
      bus.r_w      = wr;
      bus.mio_en   = 1'b1;
      bus.ld_mdr   = !wr;
      bus.main_bus = 16'h5555;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (bus.R !== 1'b1 && lat < 40);
      if (bus.R !== 1'b1) check("access_timeout", {15'h0, bus.R}, 16'h0001);
      tick();
      bus.mio_en = 1'b0;
      bus.ld_mdr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      sram[16'h3000]  = 16'h1234;
      m_mem[16'h3000] = 16'h1234;
      rst = 1'b0;
      bus.main_bus = 16'h0000;
      bus.ld_mar   = 1'b0;
      bus.ld_mdr   = 1'b0;
      bus.mio_en   = 1'b0;
      bus.r_w      = 1'b0;
      bus.kb_valid = 1'b0;
      bus.kb_data  = 8'h00;
      bus.ddr_ack  = 1'b0;
      tick();
      tick();
      rst = 1'b1;

      $display("[TB] reset state");
      check("rst_R", {15'h0, bus.R}, 16'h0000);
      check("rst_mem_en", {15'h0, bus.mem_en}, 16'h0000);
      check("rst_INT", {15'h0, bus.INT}, 16'h0000);
      check("rst_kb_ready", {15'h0, bus.kb_ready}, 16'h0001);
      check("rst_mdr", bus.mdr_out, 16'h0000);
      load_regs(16'hFE04, 16'h0000, 1'b0);
      do_access(1'b0, lat);
      check("dsr_lat", 16'(lat), 16'd1);
      check("dsr_rst", bus.mdr_out, 16'h8000);
      load_regs(16'hFE00, 16'h0000, 1'b0);
      do_access(1'b0, lat);
      check("kbsr_rst", bus.mdr_out, 16'h0000);
      load_regs(16'hFE10, 16'h7777, 1'b1);
      do_access(1'b0, lat);
      check("unmapped_rd", bus.mdr_out, 16'h0000);

      $display("[TB] sram read");
      load_regs(16'h3000, 16'h0000, 1'b0);
      bus.r_w = 1'b0; bus.mio_en = 1'b1; bus.ld_mdr = 1'b1; bus.main_bus = 16'h5555;
      tick();
      check("rd_en_t1", {15'h0, bus.mem_en}, 16'h0001);
      check("rd_we_t1", {15'h0, bus.mem_we}, 16'h0000);
      check("rd_addr_t1", bus.mem_addr, 16'h3000);
      tick();
      check("rd_en_t2", {15'h0, bus.mem_en}, 16'h0000);
      tick();
      check("rd_R_t3", {15'h0, bus.R}, 16'h0000);
      tick();
      check("rd_R_t4", {15'h0, bus.R}, 16'h0001);
      tick();
      bus.mio_en = 1'b0; bus.ld_mdr = 1'b0;
      check("rd_R_t5", {15'h0, bus.R}, 16'h0000);
      check("rd_mdr_t5", bus.mdr_out, 16'h1234);

      $display("[TB] sram write then back-to-back read");
      load_regs(16'h4000, 16'hBEEF, 1'b1);
      bus.r_w = 1'b1; bus.mio_en = 1'b1;
      tick();
      check("wr_en_t1", {15'h0, bus.mem_en}, 16'h0001);
      check("wr_we_t1", {15'h0, bus.mem_we}, 16'h0001);
      check("wr_addr_t1", bus.mem_addr, 16'h4000);
      check("wr_data_t1", bus.mem_wdata, 16'hBEEF);
      tick(); tick(); tick();
      check("wr_R_t4", {15'h0, bus.R}, 16'h0001);
      tick();
      do_access(1'b0, lat);
      check("b2b_lat", 16'(lat), 16'd4);
      check("b2b_mdr", bus.mdr_out, 16'hBEEF);
      load_regs(16'h4000, 16'h0000, 1'b1);
      do_access(1'b0, lat);
      check("reread_mdr", bus.mdr_out, 16'hBEEF);

      $display("[TB] keyboard");
      load_regs(16'hFE00, 16'h4000, 1'b1);
      do_access(1'b1, lat);
      bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
      tick();
      bus.kb_valid = 1'b0;
      check("kb_INT", {15'h0, bus.INT}, 16'h0001);
      check("kb_ready_lo", {15'h0, bus.kb_ready}, 16'h0000);
      do_access(1'b0, lat);
      check("kbsr_full", bus.mdr_out, 16'hC000);
      load_regs(16'hFE02, 16'h0000, 1'b0);
      bus.kb_valid = 1'b1; bus.kb_data = 8'h42;
      do_access(1'b0, lat);
      check("kbdr_rd", bus.mdr_out, 16'h0041);
      check("kb_INT_clr", {15'h0, bus.INT}, 16'h0000);
      check("kb_ready_clr", {15'h0, bus.kb_ready}, 16'h0001);
      tick();
      bus.kb_valid = 1'b0;
      check("kb_recapture", {15'h0, bus.kb_ready}, 16'h0000);
      do_access(1'b0, lat);
      check("kbdr_rd2", bus.mdr_out, 16'h0042);
      load_regs(16'hFE00, 16'h8000, 1'b1);
      do_access(1'b1, lat);
      do_access(1'b0, lat);
      check("kbsr_wr_ie_only", bus.mdr_out, 16'h0000);

      $display("[TB] display");
      load_regs(16'hFE06, 16'h0058, 1'b1);
      do_access(1'b1, lat);
      check("ddr_valid_set", {15'h0, bus.ddr_valid}, 16'h0001);
      check("ddr_data_58", {8'h00, bus.ddr_data}, 16'h0058);
      load_regs(16'hFE04, 16'h0000, 1'b0);
      do_access(1'b0, lat);
      check("dsr_busy", bus.mdr_out, 16'h0000);
      load_regs(16'hFE06, 16'h0059, 1'b1);
      do_access(1'b1, lat);
      check("ddr_data_59", {8'h00, bus.ddr_data}, 16'h0059);
      bus.ddr_ack = 1'b1;
      tick();
      bus.ddr_ack = 1'b0;
      check("ddr_valid_clr", {15'h0, bus.ddr_valid}, 16'h0000);
      load_regs(16'hFE04, 16'h0000, 1'b0);
      do_access(1'b0, lat);
      check("dsr_ready", bus.mdr_out, 16'h8000);

      $display("[TB] reset during access");
      load_regs(16'h3000, 16'h0000, 1'b0);
      bus.r_w = 1'b0; bus.mio_en = 1'b1; bus.ld_mdr = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1; bus.mio_en = 1'b0; bus.ld_mdr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("abort_R", {15'h0, bus.R}, 16'h0000);
         tick();
      end
      check("abort_mar", bus.mar_out, 16'h0000);
      load_regs(16'h3000, 16'h0000, 1'b0);
      do_access(1'b0, lat);
      check("post_rst_lat", 16'(lat), 16'd4);
      check("post_rst_mdr", bus.mdr_out, 16'h1234);

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory/IO interface stage directly downstream of the LC-3 microcoded control FSM.
- Owns MAR and MDR and sequences accesses to an external synchronous SRAM with configurable wait states.
- Implements the memory-mapped keyboard/display registers.
- Produces the R (ready) and INT inputs that the control FSM branches on.

Parameters:
- WAIT_STATES, 2, extra SRAM cycles per access beyond the base cycle (0..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- main_bus  in  16  datapath bus; source for MAR and for MDR when mio_en=0.
- ld_mar  in  1  load MAR from main_bus.
- ld_mdr  in  1  load MDR.
- mio_en  in  1  request a memory/IO access at MAR (control FSM holds it high until R).
- r_w  in  1  1=write MDR to [MAR], 0=read.
- mdr_out  out  16  current MDR.
- mar_out  out  16  current MAR.
- R  out  1  access complete; high for exactly one cycle.
- INT  out  1  keyboard interrupt request.
- mem_en  out  1  SRAM enable pulse.
- mem_we  out  1  SRAM write enable (valid with mem_en).
- mem_addr  out  16  SRAM address (=MAR).
- mem_wdata  out  16  SRAM write data (=MDR).
- mem_rdata  in  16  SRAM read data; valid from cycle after mem_en and held until next mem_en.
- kb_valid  in  1  keyboard character offered.
- kb_data  in  8  keyboard character.
- kb_ready  out  1  controller can accept a character (=~KBSR[15]).
- ddr_valid  out  1  display character pending.
- ddr_data  out  8  display character.
- ddr_ack  in  1  display consumed character.

Behaviour:
- Reset, rst=0 at posedge, overrides everything:
  - MAR=0, MDR=0, KBSR=x0000, KBDR=x0000, DSR=x8000, DDR=x0000.
  - ddr_valid=0, state=IDLE, wait counter=0.
  - Consequently R=0, mem_en=0, mem_we=0, INT=0, kb_ready=1.
- Reset mid-access aborts it: R never rises for that access. An SRAM write whose mem_en pulse already issued may have committed.
- Register loads:
  - ld_mar: MAR<=main_bus any cycle.
  - ld_mdr with mio_en=0: MDR<=main_bus.
  - ld_mdr with mio_en=1: MDR loads only in the DONE cycle of a read, else ignored.
- Device map (I/O page): KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06. Any other xFExx reads x0000, ignores writes. All other addresses go to SRAM.
- Access FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - mio_en=1 and MAR in SRAM space -> ACCESS, counter<=WAIT_STATES.
    - mio_en=1 and MAR in I/O page -> DONE.
    - Else stay.
  - ACCESS:
    - First ACCESS cycle: mem_en=1, mem_we=r_w; exactly one pulse per access.
    - Counter decrements each cycle; counter=0 -> DONE.
    - ACCESS therefore lasts WAIT_STATES+1 cycles.
  - DONE:
    - R=1.
    - Read: ld_mdr loads MDR from mem_rdata (SRAM) or the selected device register (I/O).
    - I/O write performs the register side effect this cycle.
    - Always -> IDLE next cycle.
- Latency: if mio_en is first sampled in IDLE at cycle t:
  - SRAM: R high at t+2+WAIT_STATES.
  - I/O: R high at t+1.
- Back-to-back: mio_en high in the IDLE cycle immediately after DONE starts a new access. There is no dead cycle beyond IDLE.
- MAR/r_w are sampled continuously. Changing them while not in IDLE is illegal; behaviour is undefined and checked only by assertion.
- KBSR:
  - Bit15 = ready, bit14 = IE; other bits read 0.
  - Writes affect bit14 only.
  - When kb_valid=1 and KBSR[15]=0: KBDR<={8'h00,kb_data} and KBSR[15]<=1.
  - A read of KBDR in DONE clears KBSR[15].
  - If a keyboard capture and a KBDR read occur in the same cycle, the read clears and the capture is refused; kb_ready was 0, so no character is lost.
- DSR:
  - Bit15 = display ready; read-only.
- DDR write in DONE:
  - DDR<=MDR, DSR[15]<=0, ddr_valid<=1.
  - Write when DSR[15]=0: overwrites the pending DDR; no new ack is required.
  - ddr_ack while ddr_valid=1: ddr_valid<=0, DSR[15]<=1.
  - ddr_data=DDR[7:0].
- INT = KBSR[15] & KBSR[14], combinational from registers.
- R, mem_en and mem_we are decoded from registered state only; there is no combinational path from mio_en.

Test Plan:
- Reset then idle -> R=0, mem_en=0, DSR read returns x8000, KBSR read returns x0000, INT=0.
- SRAM read, WAIT_STATES=2: MAR=x3000, SRAM holds x1234, mio_en high from t -> single mem_en at t+1 with mem_we=0; R only at t+4; MDR=x1234 at t+5.
- SRAM write, then back-to-back read: MDR=xBEEF, MAR=x4000, r_w=1 -> mem_we pulse with mem_addr=x4000, mem_wdata=xBEEF. Immediately re-issue as a read -> R twice, 4 cycles apart from each mio_en sample; MDR=xBEEF.
- Keyboard: write KBSR=x4000; kb_valid with kb_data=x41 -> KBSR reads xC000, INT=1, kb_ready=0. Read KBDR -> MDR=x0041; next cycle KBSR[15]=0 and INT=0.
- Display: write DDR=x0058 -> ddr_valid=1, ddr_data=x58, DSR reads x0000. Assert ddr_ack -> ddr_valid=0, DSR reads x8000.
- Reset asserted during ACCESS of an SRAM read -> R never pulses, state=IDLE. A new read afterwards completes with normal latency.
